// File: rtl/spi_eth_pkg.sv
// Shared encoder state encoding and counter widths for the SPI/Ethernet bridge pair.
package spi_eth_pkg;

  typedef enum logic [1:0] {
    EncIdle = 2'd0,
    EncSend = 2'd1,
    EncGap  = 2'd2
  } enc_state_e;

  // Half-bit counter covers HALF_PERIOD up to 255; gap counter counts half-bits.
  localparam int unsigned HALF_CNT_W = 8;
  localparam int unsigned GAP_CNT_W  = 9;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; simultaneous push and pop both succeed, even when full.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);
  assign o_rdata   = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/spi2eth.sv
// SPI (mode 0, LSB first) byte capture into a FIFO, drained by a Manchester line encoder.
module spi2eth
  import spi_eth_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 4,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic        IDLE_LEVEL  = 1'b1,
  parameter int unsigned GAP_BITS    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sck,
  input  logic mosi,
  input  logic cs,
  output logic eth_line,
  output logic tx_active,
  output logic overflow
);

  localparam logic [HALF_CNT_W-1:0] HalfLast = HALF_CNT_W'(HALF_PERIOD - 1);
  localparam logic [GAP_CNT_W-1:0]  GapLast  = GAP_CNT_W'(2 * GAP_BITS - 1);

  logic [1:0] r_sck_sync;
  logic [1:0] r_mosi_sync;
  logic [1:0] r_cs_sync;
  logic       r_sck_prev;
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic       r_overflow;

  logic       w_sck_rise;
  logic       w_push;
  logic [7:0] w_push_byte;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;
  logic [7:0] w_rdata;

  assign w_sck_rise  = r_sck_sync[1] & ~r_sck_prev;
  assign w_push      = ~r_cs_sync[1] & w_sck_rise & (r_bit_cnt == 3'd7);
  assign w_push_byte = {r_mosi_sync[1], r_shift[7:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sck_sync  <= 2'b00;
      r_mosi_sync <= 2'b00;
      r_cs_sync   <= 2'b11;
      r_sck_prev  <= 1'b0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[0], sck};
      r_mosi_sync <= {r_mosi_sync[0], mosi};
      r_cs_sync   <= {r_cs_sync[0], cs};
      r_sck_prev  <= r_sck_sync[1];
      // cs high drops any partial byte; the counter wraps 7->0 on a full byte.
      if (r_cs_sync[1]) begin
        r_bit_cnt <= '0;
      end else if (w_sck_rise) begin
        r_shift   <= w_push_byte;
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_push),
    .i_wdata(w_push_byte),
    .i_pop  (w_pop),
    .o_rdata(w_rdata),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  enc_state_e            r_state, w_state_nxt;
  logic [7:0]            r_byte, w_byte_nxt;
  logic [2:0]            r_bit_idx, w_bit_idx_nxt;
  logic                  r_phase, w_phase_nxt;
  logic [HALF_CNT_W-1:0] r_half_cnt, w_half_nxt;
  logic [GAP_CNT_W-1:0]  r_gap_cnt, w_gap_nxt;
  logic                  r_line, w_line_nxt;
  logic                  w_load;
  logic [2:0]            w_next_idx;

  assign w_next_idx = r_bit_idx + 3'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= EncIdle;
      r_byte     <= '0;
      r_bit_idx  <= '0;
      r_phase    <= 1'b0;
      r_half_cnt <= '0;
      r_gap_cnt  <= '0;
      r_line     <= IDLE_LEVEL;
    end else begin
      r_state    <= w_state_nxt;
      r_byte     <= w_byte_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_phase    <= w_phase_nxt;
      r_half_cnt <= w_half_nxt;
      r_gap_cnt  <= w_gap_nxt;
      r_line     <= w_line_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_byte_nxt    = r_byte;
    w_bit_idx_nxt = r_bit_idx;
    w_phase_nxt   = r_phase;
    w_half_nxt    = r_half_cnt;
    w_gap_nxt     = r_gap_cnt;
    w_line_nxt    = r_line;
    w_load        = 1'b0;
    w_pop         = 1'b0;
    unique case (r_state)
      EncIdle: begin
        w_line_nxt = IDLE_LEVEL;
        if (!w_empty) w_load = 1'b1;
      end
      EncSend: begin
        if (r_half_cnt != HalfLast) begin
          w_half_nxt = r_half_cnt + HALF_CNT_W'(1);
        end else begin
          w_half_nxt = '0;
          if (!r_phase) begin
            w_phase_nxt = 1'b1;
            w_line_nxt  = r_byte[r_bit_idx];
          end else if (r_bit_idx != 3'd7) begin
            w_phase_nxt   = 1'b0;
            w_bit_idx_nxt = w_next_idx;
            w_line_nxt    = ~r_byte[w_next_idx];
          end else if (!w_empty) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = EncGap;
            w_line_nxt  = IDLE_LEVEL;
            w_gap_nxt   = '0;
          end
        end
      end
      EncGap: begin
        w_line_nxt = IDLE_LEVEL;
        if (r_half_cnt != HalfLast) begin
          w_half_nxt = r_half_cnt + HALF_CNT_W'(1);
        end else begin
          w_half_nxt = '0;
          if (r_gap_cnt == GapLast) w_state_nxt = EncIdle;
          else                      w_gap_nxt   = r_gap_cnt + GAP_CNT_W'(1);
        end
      end
      default: w_state_nxt = EncIdle;
    endcase
    // Loading a byte drives the first half of bit 0 on the very next edge.
    if (w_load) begin
      w_pop         = 1'b1;
      w_byte_nxt    = w_rdata;
      w_bit_idx_nxt = '0;
      w_phase_nxt   = 1'b0;
      w_half_nxt    = '0;
      w_line_nxt    = ~w_rdata[0];
      w_state_nxt   = EncSend;
    end
  end

  assign eth_line  = r_line;
  assign tx_active = (r_state == EncSend);
  assign overflow  = r_overflow;

endmodule

// File: doc/spi2eth.md
SPI2ETH -- requirements
Module: spi2eth

Interface
REQ-001 Parameter HALF_PERIOD, default 4: clk cycles per Manchester half-bit; legal range 2..255.
REQ-002 Parameter FIFO_DEPTH, default 4: byte FIFO entries; power of two, 2..16.
REQ-003 Parameter IDLE_LEVEL, default 1'b1: eth_line level when not transmitting.
REQ-004 Parameter GAP_BITS, default 4: minimum idle bit periods between frames.
REQ-005 clk  input  1  single system clock; all logic on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 sck  input  1  SPI clock, asynchronous to clk; mode 0.
REQ-008 mosi  input  1  SPI data, LSB first.
REQ-009 cs  input  1  SPI chip select, active-low.
REQ-010 eth_line  output  1  Manchester-encoded serial line.
REQ-011 tx_active  output  1  high while a frame is on the line (SEND state).
REQ-012 overflow  output  1  sticky; set when a byte arrives with the FIFO full.

Function
REQ-013 sck, mosi and cs SHALL each pass through a 2-flop synchronizer before use; the sck rising edge SHALL be detected from the synchronized copy.
REQ-014 On each detected sck rising edge with synchronized cs low, mosi SHALL be shifted in LSB first; a bit counter SHALL count 0..7.
REQ-015 On the 8th bit, the assembled byte SHALL be pushed into the FIFO in the same cycle; if the FIFO is full, the byte SHALL be dropped and overflow set.
REQ-016 On cs going high, a partial byte (1..7 bits) SHALL be discarded and the bit counter cleared; cs high SHALL also mark end-of-frame.
REQ-017 sck SHALL be guaranteed by the system to have high and low phases of at least 3 clk cycles; faster sck is out of scope.
REQ-018 Encoder states: IDLE, SEND, GAP.
REQ-019 IDLE: eth_line = IDLE_LEVEL; on FIFO non-empty, pop one byte and enter SEND in the next cycle.
REQ-020 SEND: each bit lasts 2*HALF_PERIOD cycles; the first half drives ~bit, the second half drives bit (1 = low-then-high, 0 = high-then-low); bits are sent LSB first.
REQ-021 After bit 7 of a byte: if the FIFO is non-empty, pop the next byte and continue with no gap; otherwise enter GAP.
REQ-022 GAP: eth_line = IDLE_LEVEL for GAP_BITS*2*HALF_PERIOD cycles, then IDLE; FIFO data arriving during GAP waits until IDLE.
REQ-023 FIFO empty mid-frame (SPI underrun) SHALL end the frame per REQ-021; it is not an error.
REQ-024 FIFO push and pop in the same cycle SHALL both succeed, including when full.
REQ-025 Latency: first eth_line transition of a frame SHALL occur at most 4 clk cycles after the FIFO push of its first byte, when the encoder is in IDLE.
REQ-026 overflow SHALL clear only on reset.

Reset
REQ-027 While rst_n is low at a clk edge: state IDLE, eth_line = IDLE_LEVEL, tx_active = 0, overflow = 0, FIFO empty, shift register and bit counter cleared, synchronizers loaded with sck=0, cs=1.
REQ-028 Reset mid-frame SHALL abort the frame immediately; no partial bit SHALL complete after rst_n goes low.

Structure
REQ-029 Encoder state encoding and the GAP/halfbit counter widths SHALL live in a shared package spi_eth_pkg, reused by eth2spi-side code.
REQ-030 The byte FIFO SHALL be a separate sub-module sync_fifo (parameterized width, depth); the SPI capture and Manchester encoder stay in spi2eth.

Verification
REQ-031 Send 8 bytes 0x55,0x00,0xE5,0x88,0xC3,0x77,0x9A,0x2F in one cs-low burst, sck period 16 clk -> decoded eth_line yields 64'h2f9a77c388e50055 LSB first, tx_active high continuously, eth_line = 1 after GAP.
REQ-032 Repeat REQ-031 with IDLE_LEVEL=0 -> identical decoded data, line rests at 0.
REQ-033 Send 0xA5 then raise cs after 3 more bits -> exactly one byte 0xA5 transmitted, trailing bits absent.
REQ-034 FIFO_DEPTH=2, HALF_PERIOD=16, 4 bytes at sck period 8 -> overflow = 1, first 3 bytes transmitted (one popped immediately plus two buffered), 4th lost.
REQ-035 Assert rst_n low during bit 3 of byte 0x0F -> next cycle eth_line = IDLE_LEVEL, tx_active = 0; subsequent byte 0x3C transmits correctly.
REQ-036 Two single-byte frames 200 clk apart -> the two SEND periods are separated by at least GAP_BITS*2*HALF_PERIOD idle cycles.
